// File: rtl/hs_npu_pkg.sv
// Shared AXI encodings and responder state type for the NPU memory responder.
package hs_npu_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_t;

    localparam logic [2:0] AXI_SIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RDATA
    } resp_state_t;

    // Only full-word INCR or FIXED bursts are served; WRAP and the reserved code are rejected.
    function automatic logic burst_is_bad(input logic [2:0] size, input logic [1:0] burst);
        return (size != AXI_SIZE_WORD) || (burst == BURST_WRAP) || (burst == 2'b11);
    endfunction

endpackage

// File: rtl/hs_npu_axi_mem_sram.sv
// Single-port word SRAM with byte write enables and a registered read port.
module hs_npu_axi_mem_sram #(
    parameter int MEM_WORDS = 4096,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    i_wen,
    input  logic          i_ren,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [MEM_WORDS];

    // The read register only changes on a read, so it holds a stalled beat by itself.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_wen[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
        if (i_ren) o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/hs_npu_axi_mem_responder.sv
// AXI4 burst slave backed by a word SRAM; serves one write or one read transaction at a time.
module hs_npu_axi_mem_responder
    import hs_npu_pkg::*;
#(
    parameter int          ID_WIDTH  = 8,
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                mem_awready,
    input  logic                mem_awvalid,
    input  logic [ID_WIDTH-1:0] mem_awid,
    input  logic [7:0]          mem_awlen,
    input  logic [31:0]         mem_awaddr,
    input  logic [2:0]          mem_awsize,
    input  logic [1:0]          mem_awburst,
    input  logic [2:0]          mem_awprot,
    output logic                mem_wready,
    input  logic                mem_wvalid,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_wstrb,
    input  logic                mem_wlast,
    output logic                mem_bvalid,
    input  logic                mem_bready,
    output logic [ID_WIDTH-1:0] mem_bid,
    output logic [1:0]          mem_bresp,
    output logic                mem_arready,
    input  logic                mem_arvalid,
    input  logic [ID_WIDTH-1:0] mem_arid,
    input  logic [7:0]          mem_arlen,
    input  logic [31:0]         mem_araddr,
    input  logic [2:0]          mem_arsize,
    input  logic [1:0]          mem_arburst,
    input  logic [2:0]          mem_arprot,
    output logic                mem_rvalid,
    input  logic                mem_rready,
    output logic [ID_WIDTH-1:0] mem_rid,
    output logic [31:0]         mem_rdata,
    output logic [1:0]          mem_rresp,
    output logic                mem_rlast
);

    localparam int AW = $clog2(MEM_WORDS);

    resp_state_t         r_state;
    logic                r_live;
    logic                r_prio;
    logic [ID_WIDTH-1:0] r_id;
    logic [7:0]          r_cnt;
    logic [31:0]         r_addr;
    logic                r_fixed;
    logic                r_burst_err;
    logic                r_any_err;
    logic                r_bvalid;
    axi_resp_t           r_bresp;
    logic                r_rvalid;
    logic                r_rlast;
    axi_resp_t           r_rresp;
    logic                r_rerr;
    logic                r_rdone;

    logic [31:0]   w_off;
    logic          w_in_win;
    logic          w_beat_err;
    logic [AW-1:0] w_idx;
    logic          w_point_wr;
    logic          w_aw_hs;
    logic          w_ar_hs;
    logic          w_tie;
    logic          w_w_hs;
    logic          w_w_err;
    logic          w_r_issue;
    logic [31:0]   w_sram_q;
    logic [2:0]    w_sel_size;
    logic [1:0]    w_sel_burst;
    logic          w_unused;

    // Subtracting the base first lets addresses below the window wrap to huge offsets.
    assign w_off      = r_addr - BASE_ADDR;
    assign w_in_win   = {2'b00, w_off[31:2]} < 32'(MEM_WORDS);
    assign w_beat_err = r_burst_err || !w_in_win;
    assign w_idx      = w_off[AW+1:2];

    // A lone request takes the port; only a tie consults and flips the priority flag.
    assign w_tie      = mem_awvalid && mem_arvalid;
    assign w_point_wr = w_tie ? !r_prio : (mem_awvalid || (!mem_arvalid && !r_prio));

    assign mem_awready = r_live && (r_state == ST_IDLE) && w_point_wr;
    assign mem_arready = r_live && (r_state == ST_IDLE) && !w_point_wr;
    assign w_aw_hs     = mem_awvalid && mem_awready;
    assign w_ar_hs     = mem_arvalid && mem_arready;
    assign w_sel_size  = w_aw_hs ? mem_awsize  : mem_arsize;
    assign w_sel_burst = w_aw_hs ? mem_awburst : mem_arburst;

    assign mem_wready = (r_state == ST_WDATA);
    assign w_w_hs     = mem_wvalid && mem_wready;
    assign w_w_err    = w_beat_err || (mem_wlast != (r_cnt == 8'd0));
    assign w_r_issue  = (r_state == ST_RDATA) && !r_rdone && (!r_rvalid || mem_rready);

    assign mem_bvalid = r_bvalid;
    assign mem_bid    = r_id;
    assign mem_bresp  = r_bresp;
    assign mem_rvalid = r_rvalid;
    assign mem_rid    = r_id;
    assign mem_rresp  = r_rresp;
    assign mem_rlast  = r_rlast;
    assign mem_rdata  = (r_rvalid && !r_rerr) ? w_sram_q : 32'h0;

    assign w_unused = ^{mem_awprot, mem_arprot, w_off[1:0]};

    hs_npu_axi_mem_sram #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_sram (
        .clk     (clk),
        .i_wen   ((w_w_hs && !w_beat_err) ? mem_wstrb : 4'b0000),
        .i_ren   (w_r_issue && !w_beat_err),
        .i_addr  (w_idx),
        .i_wdata (mem_wdata),
        .o_rdata (w_sram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_live      <= 1'b0;
            r_prio      <= 1'b0;
            r_id        <= '0;
            r_cnt       <= 8'd0;
            r_addr      <= 32'h0;
            r_fixed     <= 1'b0;
            r_burst_err <= 1'b0;
            r_any_err   <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= RESP_OKAY;
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
            r_rresp     <= RESP_OKAY;
            r_rerr      <= 1'b0;
            r_rdone     <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_aw_hs || w_ar_hs) begin
                        if (w_tie) r_prio <= ~r_prio;
                        r_id        <= w_aw_hs ? mem_awid   : mem_arid;
                        r_cnt       <= w_aw_hs ? mem_awlen  : mem_arlen;
                        r_addr      <= w_aw_hs ? mem_awaddr : mem_araddr;
                        r_fixed     <= (w_sel_burst == BURST_FIXED);
                        r_burst_err <= burst_is_bad(w_sel_size, w_sel_burst);
                        r_any_err   <= 1'b0;
                        r_rdone     <= 1'b0;
                        r_state     <= w_aw_hs ? ST_WDATA : ST_RDATA;
                    end
                end
                ST_WDATA: begin
                    if (w_w_hs) begin
                        if (r_cnt == 8'd0) begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_any_err || w_w_err) ? RESP_SLVERR : RESP_OKAY;
                            r_state  <= ST_WRESP;
                        end else begin
                            r_cnt     <= r_cnt - 8'd1;
                            r_any_err <= r_any_err || w_w_err;
                            if (!r_fixed) r_addr <= r_addr + 32'd4;
                        end
                    end
                end
                ST_WRESP: begin
                    if (mem_bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RDATA: begin
                    if (w_r_issue) begin
                        r_rvalid <= 1'b1;
                        r_rlast  <= (r_cnt == 8'd0);
                        r_rresp  <= w_beat_err ? RESP_SLVERR : RESP_OKAY;
                        r_rerr   <= w_beat_err;
                        if (r_cnt == 8'd0) begin
                            r_rdone <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                            if (!r_fixed) r_addr <= r_addr + 32'd4;
                        end
                    end else if (mem_rready) begin
                        r_rvalid <= 1'b0;
                    end
                    if (r_rvalid && mem_rready && r_rlast) begin
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
